// File: rtl/ins_mem_pkg.sv
// Instruction memory package: word/address widths, the instruction field
// layout used to assemble the boot program, and the boot program image.
package ins_mem_pkg;

    localparam int INS_W      = 16;
    localparam int INS_ADDR_W = 16;

    localparam logic [INS_W-1:0] NOP = 16'h0000;

    // Instruction layout: [15:12] opcode, [11:8] destination, [7:0] immediate/mode
    localparam int OP_W  = 4;
    localparam int REG_W = 4;
    localparam int IMM_W = 8;

    localparam logic [OP_W-1:0] OP_LDI = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_BNZ = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP = 4'h9;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    function automatic logic [INS_W-1:0] mk_ins(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rd,
        input logic [IMM_W-1:0] imm
    );
        return {op, rd, imm};
    endfunction

    localparam int PROG_LEN = 12;

    localparam logic [INS_W-1:0] PROG_IMAGE [PROG_LEN] = '{
        mk_ins(OP_LDI, 4'd1, 8'h0A),
        mk_ins(OP_LDI, 4'd2, 8'h03),
        mk_ins(OP_ADD, 4'd1, 8'h12),
        mk_ins(OP_SUB, 4'd2, 8'h21),
        mk_ins(OP_LDI, 4'd3, 8'h55),
        mk_ins(OP_ADD, 4'd3, 8'h31),
        mk_ins(OP_BNZ, 4'd2, 8'h02),
        mk_ins(OP_LDI, 4'd4, 8'hC0),
        mk_ins(OP_ADD, 4'd4, 8'h43),
        mk_ins(OP_SUB, 4'd4, 8'h41),
        mk_ins(OP_JMP, 4'd0, 8'h00),
        mk_ins(OP_HLT, 4'd0, 8'hFF)
    };

    // Boot word at a given index; anything past the program is a NOP.
    function automatic logic [INS_W-1:0] image_word(input int idx);
        logic [INS_W-1:0] w;
        w = NOP;
        if ((idx >= 0) && (idx < PROG_LEN)) begin
            w = PROG_IMAGE[idx];
        end else begin
            w = NOP;
        end
        return w;
    endfunction

endpackage

// File: rtl/ins_fetch_mem_if.sv
// Fetch-side request/response bus of the instruction memory.
// master = fetch/decode side, slave = instruction memory.
interface ins_fetch_mem_if
    import ins_mem_pkg::*;
#(
    parameter int DATA_W = INS_W,
    parameter int ADDR_W = INS_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/ins_mem_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Push and pop may happen together at any occupancy, including full.
// clr empties the queue synchronously and wins over push/pop.
module ins_mem_fifo
    import ins_mem_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [W-1:0]     buf_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? {PTR_W{1'b0}} : (p + PTR_W'(1'b1));
    endfunction

    // Decide which ends of the queue move this cycle
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        full_s    = (count_r == FULL_C);
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; never read while empty, so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push_s && !clr) begin
            buf_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = empty_s ? {W{1'b0}} : buf_r[rd_ptr_r];
    assign valid = ~empty_s;
    assign count = count_r;

endmodule

// File: rtl/ins_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a one-cycle read stage
// and a response FIFO so decode can stall without losing fetched words.
// Out-of-range addresses return a zero word flagged with rsp_err; flush
// discards the in-flight read and every queued response.
// Optional feature macro: INS_MEM_LOAD_EN adds the ld_* program-load port;
// without it the array is the read-only PROG_IMAGE.
module ins_fetch_mem
    import ins_mem_pkg::*;
#(
    parameter int DATA_W    = INS_W,
    parameter int ADDR_W    = INS_ADDR_W,
    parameter int DEPTH     = 16,
    parameter int OUT_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef INS_MEM_LOAD_EN
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`endif
    ins_fetch_mem_if.slave    bus
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int ENT_W = DATA_W + ADDR_W + 1;
    localparam logic [ADDR_W:0]  DEPTH_C     = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W:0]   OUT_DEPTH_C = (CNT_W + 1)'(OUT_DEPTH);

    logic              rd_in_range_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              req_ready_s;
    logic              accept_s;
    logic [CNT_W:0]    credit_used_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [ENT_W-1:0]  fifo_dout_s;
    logic              fifo_valid_s;

    logic              s1_valid_r;
    logic [ADDR_W-1:0] s1_addr_r;
    logic [DATA_W-1:0] s1_data_r;
    logic              s1_err_r;

`ifdef INS_MEM_LOAD_EN
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t boot_image();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(image_word(i));
        end
        return m;
    endfunction

    // Writable array, seeded with the boot program and not touched by reset
    mem_t mem_r = boot_image();

    // Program-load write; addresses beyond the array are dropped
    always_ff @(posedge clk) begin
        if (ld_en && ({1'b0, ld_addr} < DEPTH_C)) begin
            mem_r[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end
`endif

    // Array lookup for the presented address, compared on all address bits
    always_comb begin
        rd_in_range_s = ({1'b0, bus.req_addr} < DEPTH_C);
        rd_data_s     = {DATA_W{1'b0}};
        if (rd_in_range_s) begin
`ifdef INS_MEM_LOAD_EN
            rd_data_s = mem_r[bus.req_addr[IDX_W-1:0]];
`else
            rd_data_s = DATA_W'(image_word(int'(bus.req_addr)));
`endif
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    // Credit check: a request is taken only if its word is sure of a FIFO slot
    always_comb begin
        credit_used_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, s1_valid_r};
        req_ready_s   = 1'b0;
        if (flush) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = (credit_used_s < OUT_DEPTH_C);
        end
    end

    assign accept_s      = bus.req_valid & req_ready_s;
    assign bus.req_ready = req_ready_s;

    // Read stage: capture the looked-up word; drains into the FIFO every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= {ADDR_W{1'b0}};
            s1_data_r  <= {DATA_W{1'b0}};
            s1_err_r   <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_addr_r <= bus.req_addr;
                s1_data_r <= rd_data_s;
                s1_err_r  <= ~rd_in_range_s;
            end
        end
    end

    ins_mem_fifo #(
        .W     (ENT_W),
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (s1_valid_r),
        .din   ({s1_err_r, s1_addr_r, s1_data_r}),
        .pop   (bus.rsp_ready),
        .dout  (fifo_dout_s),
        .valid (fifo_valid_s),
        .count (fifo_count_s)
    );

    assign bus.rsp_valid = fifo_valid_s;
    assign {bus.rsp_err, bus.rsp_addr, bus.rsp_data} = fifo_dout_s;

endmodule
